// File: rtl/x6_rr_merger.sv
// x6_rr_merger: round-robin merger for six FIFO channels.
// Pops one ready channel per cycle, tags the word with its channel number and
// presents it on a single valid/ready output stream. A run/drain FSM lets the
// acquisition controller stop once every channel has gone quiet.
//
// Output handshake: dout/dvalid form a valid/ready pair. A word transfers on
// any rising edge where dvalid=1 and dready=1. While dvalid=1 and dready=0,
// dout is held stable and no new pop is issued. A new word may be loaded in
// the same cycle that the previous one is accepted.
module x6_rr_merger #(
   parameter int NCH         = 6,
   parameter int DW          = 32,
   parameter int HOLDOFF     = 2,
   parameter int DRAIN_QUIET = 4,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              init,
   input  logic              enable,
   input  logic [NCH-1:0]    pok,
   input  logic [NCH*DW-1:0] din,
   output logic [NCH-1:0]    pop,
   output logic [DW+2:0]     dout,
   output logic              dvalid,
   input  logic              dready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  word_cnt,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int HW = $clog2(HOLDOFF + 1);
   localparam int QW = $clog2(DRAIN_QUIET + 1);

   state_t         state;
   state_t         state_nxt;
   logic [2:0]     ptr;
   logic [HW-1:0]  hold_cnt [NCH];
   logic [NCH-1:0] mask;
   logic [NCH-1:0] elig;
   logic [QW-1:0]  quiet_cnt;
   logic           grant;
   logic [2:0]     win;
   logic [DW-1:0]  win_data;
   int             idx;

   assign fsm_state = state;

   // A channel stays masked while its holdoff counter is non-zero.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NCH; i++) begin
         mask[i] = (hold_cnt[i] != '0);
      end
   end

   // Round-robin search starting at ptr; grant only when the output slot can take a word.
   always_comb begin
      elig  = pok & ~mask;
      grant = 1'b0;
      win   = '0;
      idx   = 0;
      if ((state == S_RUN || state == S_DRAIN) && (!dvalid || dready)) begin
         for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!grant && elig[3'(idx)]) begin
               grant = 1'b1;
               win   = 3'(idx);
            end
         end
      end
   end

   // One-hot pop strobe and the data slice of the winning channel.
   always_comb begin
      pop      = '0;
      win_data = '0;
      if (grant) begin
         pop[win] = 1'b1;
      end
      for (int k = 0; k < NCH; k++) begin
         if (win == 3'(k)) begin
            win_data = din[k*DW +: DW];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (!enable) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (enable) begin
               state_nxt = S_RUN;
            end else if (quiet_cnt == QW'(DRAIN_QUIET) && !dvalid) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Quiet counter: cleared in RUN, counts all-empty cycles in DRAIN, saturates at the threshold.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         quiet_cnt <= '0;
      end else if (state == S_RUN) begin
         quiet_cnt <= '0;
      end else if (state == S_DRAIN) begin
         if (pok != '0) begin
            quiet_cnt <= '0;
         end else if (quiet_cnt != QW'(DRAIN_QUIET)) begin
            quiet_cnt <= quiet_cnt + QW'(1);
         end
      end
   end

   // Holdoff counters: loaded on a pop so the channel is skipped until its pok has updated.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         for (int i = 0; i < NCH; i++) hold_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (grant && win == 3'(i)) begin
               hold_cnt[i] <= HW'(HOLDOFF);
            end else if (hold_cnt[i] != '0) begin
               hold_cnt[i] <= hold_cnt[i] - HW'(1);
            end
         end
      end
   end

   // Rotate the priority pointer to the channel after the winner.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         ptr <= '0;
      end else if (grant) begin
         ptr <= (win == 3'(NCH - 1)) ? 3'd0 : win + 3'd1;
      end
   end

   // Output register: load on grant, release the slot when accepted with nothing new.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         dout   <= '0;
         dvalid <= 1'b0;
      end else if (grant) begin
         dout   <= {win, win_data};
         dvalid <= 1'b1;
      end else if (dready) begin
         dvalid <= 1'b0;
      end
   end

   // Word counter: restarts on RUN entry from IDLE, saturates at all-ones.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         word_cnt <= '0;
      end else if (state == S_IDLE && enable) begin
         word_cnt <= '0;
      end else if (grant && word_cnt != '1) begin
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_x6_rr_merger.sv
// tb_x6_rr_merger: randomized and directed bench for x6_rr_merger.
// An upstream FIFO model feeds pok/din; a cycle-level reference model predicts
// pop, dout, dvalid, busy, done and word_cnt; a queue tracks issued words.
module tb_x6_rr_merger;

   localparam int NCH         = 6;
   localparam int DW          = 32;
   localparam int HOLDOFF     = 2;
   localparam int DRAIN_QUIET = 4;
   localparam int CNT_W       = 16;
   localparam int W           = DW + 3;

   logic              clk = 1'b0;
   logic              init;
   logic              enable;
   logic [NCH-1:0]    pok;
   logic [NCH*DW-1:0] din;
   logic [NCH-1:0]    pop;
   logic [W-1:0]      dout;
   logic              dvalid;
   logic              dready;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  word_cnt;
   logic [1:0]        fsm_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   x6_rr_merger #(
      .NCH(NCH), .DW(DW), .HOLDOFF(HOLDOFF), .DRAIN_QUIET(DRAIN_QUIET), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .init(init), .enable(enable), .pok(pok), .din(din), .pop(pop),
      .dout(dout), .dvalid(dvalid), .dready(dready), .busy(busy), .done(done),
      .word_cnt(word_cnt), .fsm_state(fsm_state)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------- scoreboard / model state ----------------
   logic [W-1:0]   exp_q[$];
   int             depth [NCH];
   logic [DW-1:0]  head  [NCH];
   bit             feed_on;
   int             feed_pct;
   int             m_mode;      // 0 idle, 1 run, 2 drain, 3 done
   int             m_ptr;
   int             m_cnt;
   int             m_quiet;
   bit             m_dvalid;
   logic [W-1:0]   m_dout;
   int             last_pop [NCH];
   int             cyc;
   logic [NCH-1:0] pop_obs;
   int             done_seen;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_ptr    = 0;
      m_cnt    = 0;
      m_quiet  = 0;
      m_dvalid = 1'b0;
      m_dout   = '0;
      for (int i = 0; i < NCH; i++) begin
         last_pop[i] = -1000000;
         depth[i]    = 0;
         head[i]     = $urandom;
      end
      exp_q.delete();
   endtask

   // ---------------- driver ----------------
   task automatic drive_inputs();
      for (int i = 0; i < NCH; i++) begin
         pok[i]           = (depth[i] > 0);
         din[i*DW +: DW]  = head[i];
      end
   endtask

   // Compare DUT against the model for the current cycle, then advance the model.
   task automatic eval_cycle();
      logic [NCH-1:0] exp_pop;
      logic [W-1:0]   word;
      logic [2:0]     tag3;
      bit             g;
      bit             dv_now;
      int             w;
      int             ch;
      exp_pop = '0;
      g = 1'b0;
      w = 0;
      if ((m_mode == 1 || m_mode == 2) && (!m_dvalid || dready)) begin
         for (int k = 0; k < NCH; k++) begin
            ch = (m_ptr + k) % NCH;
            if (!g && pok[ch] && (cyc - last_pop[ch] > HOLDOFF)) begin
               g = 1'b1;
               w = ch;
            end
         end
      end
      if (g) exp_pop[w] = 1'b1;

      check("pop", pop, exp_pop);
      check("dvalid", dvalid, m_dvalid);
      check("dout", dout, m_dout);
      check("busy", busy, (m_mode == 1 || m_mode == 2));
      check("done", done, (m_mode == 3));
      check("word_cnt", word_cnt, m_cnt);
      pop_obs = pop;
      if (done) done_seen++;

      if (dvalid && dready) begin
         if (exp_q.size() == 0) check("sb_level", exp_q.size(), 1);
         else                   check("sb_word", dout, exp_q.pop_front());
      end

      dv_now = m_dvalid;
      if (g) begin
         tag3 = w[2:0];
         word = {tag3, din[w*DW +: DW]};
         exp_q.push_back(word);
         m_dout      = word;
         m_dvalid    = 1'b1;
         m_ptr       = (w + 1) % NCH;
         if (m_cnt < 65535) m_cnt++;
         last_pop[w] = cyc;
      end else if (dready) begin
         m_dvalid = 1'b0;
      end

      case (m_mode)
         0: if (enable) begin m_mode = 1; m_cnt = 0; end
         1: if (!enable) begin m_mode = 2; m_quiet = 0; end
         2: begin
            if (enable) m_mode = 1;
            else if (m_quiet >= DRAIN_QUIET && !dv_now) m_mode = 3;
            if (pok == '0) m_quiet = (m_quiet < DRAIN_QUIET) ? m_quiet + 1 : DRAIN_QUIET;
            else           m_quiet = 0;
         end
         default: m_mode = 0;
      endcase
      cyc++;
   endtask

   // Upstream FIFOs: consume on pop, optionally refill at random.
   task automatic upstream_update();
      for (int i = 0; i < NCH; i++) begin
         if (pop_obs[i] && depth[i] > 0) begin
            depth[i]--;
            head[i] = $urandom;
         end
         if (feed_on && depth[i] < 8 && $urandom_range(99) < feed_pct) depth[i]++;
      end
   endtask

   task automatic step();
      drive_inputs();
      #1;
      eval_cycle();
      @(posedge clk);
      #1;
      upstream_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      init    = 1'b1;
      enable  = 1'b0;
      dready  = 1'b0;
      feed_on = 1'b0;
      model_reset();
      drive_inputs();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      init = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      cyc = 0;
      done_seen = 0;
      feed_pct = 30;
      pop_obs = '0;
      pok = '0;
      din = '0;
      do_reset();
      step();   // reset state comparison through the model

      // Single channel: pop, captured word, holdoff.
      enable = 1'b1; dready = 1'b1;
      depth[0] = 5; head[0] = 32'h0000_00A5;
      step();                                   // IDLE -> RUN, no pop
      check("t1_idle_pop", pop_obs, '0);
      step();
      check("t1_pop", pop_obs, 6'b000001);
      check("t1_dout", dout, {3'd0, 32'h0000_00A5});
      check("t1_dvalid", dvalid, 1'b1);
      step(); check("t1_hold1", pop_obs, '0);
      step(); check("t1_hold2", pop_obs, '0);
      step(); check("t1_repop", pop_obs, 6'b000001);

      // All channels full: strict rotation.
      do_reset();
      enable = 1'b1; dready = 1'b1;
      for (int i = 0; i < NCH; i++) depth[i] = 10;
      step();
      for (int i = 0; i < 7; i++) begin
         step();
         check("t2_order", pop_obs, NCH'(1) << (i % NCH));
      end
      check("t2_word_cnt", word_cnt, 7);

      // Output stall: no pops while dready is low, resume on ch1.
      dready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_stall_pop", pop_obs, '0);
         check("t3_stall_dv", dvalid, 1'b1);
      end
      dready = 1'b1;
      step();
      check("t3_resume", pop_obs, 6'b000010);

      // Pointer at 3: ch5 wins before ch2.
      do_reset();
      enable = 1'b1; dready = 1'b1;
      step();
      depth[2] = 1;
      step(); check("t4_first", pop_obs, 6'b000100);
      step(); step(); step();
      depth[2] = 1; depth[5] = 1;
      step(); check("t4_ch5", pop_obs, 6'b100000);
      step(); check("t4_ch2", pop_obs, 6'b000100);

      // Random traffic with occasional enable dips.
      do_reset();
      enable = 1'b1;
      feed_on = 1'b1;
      for (int ph = 0; ph < 4; ph++) begin
         int rdy_pct;
         rdy_pct  = $urandom_range(30, 100);
         feed_pct = $urandom_range(10, 60);
         for (int i = 0; i < 120; i++) begin
            dready = ($urandom_range(99) < rdy_pct);
            if ($urandom_range(99) < 3) enable = ~enable;
            step();
         end
      end

      // Drain: stop feeding, drop enable, everything pending must come out.
      enable = 1'b1;
      feed_pct = 60;
      for (int i = 0; i < 30; i++) begin
         dready = ($urandom_range(99) < 70);
         step();
      end
      feed_on = 1'b0;
      enable  = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 400 && done_seen == 0; i++) begin
         dready = ($urandom_range(99) < 70);
         step();
      end
      check("t5_done_seen", done_seen, 1);
      dready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("t5_done_once", done_seen, 1);
      check("t5_busy", busy, 1'b0);
      check("t5_sb_empty", exp_q.size(), 0);
      for (int i = 0; i < NCH; i++) check("t5_fifo_empty", depth[i], 0);

      // Reset mid-stream: outputs clear asynchronously.
      enable = 1'b1; feed_on = 1'b1; feed_pct = 50;
      for (int i = 0; i < 20; i++) begin
         dready = (i < 15);
         step();
      end
      drive_inputs();
      #1;
      init = 1'b1;
      #1;
      check("t6_pop", pop, '0);
      check("t6_dvalid", dvalid, 1'b0);
      check("t6_word_cnt", word_cnt, 0);
      check("t6_busy", busy, 1'b0);
      feed_on = 1'b0;
      enable  = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      init = 1'b0;
      for (int i = 0; i < 3; i++) step();
      enable = 1'b1; dready = 1'b1; feed_on = 1'b1;
      for (int i = 0; i < 40; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
      $fatal(1, "time limit");
   end

endmodule
